reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of in-flight entries; power of two.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports disp_valid_1/disp_valid_2  input  1 each  dispatch request, instr_1 is older.
REQ-005 SHALL have ports disp_dest_1/disp_dest_2  input  3 each  ARF destination.
REQ-006 SHALL have ports disp_wr_1/disp_wr_2  input  1 each  instruction writes a register.
REQ-007 SHALL have ports disp_tag_1/disp_tag_2  input  5 each  allocated RRF tag.
REQ-008 SHALL have ports disp_idx_1/disp_idx_2  output  4 each  ROB index assigned (tail, tail+1 mod depth).
REQ-009 SHALL have port rob_full  output  1  fewer than 2 free entries.
REQ-010 SHALL have port rob_count  output  5  occupied entries, 0..16.
REQ-011 SHALL have ports cmp_valid  input  1, cmp_idx  input  4, cmp_data  input  16  execution completion.
REQ-012 SHALL have port commit_arf_tag  input  5  current ARF tag of register wb_arf_addr (external mux).
REQ-013 SHALL have ports wb_arf_addr  output  3, wb_data  output  16, wb_valid  output  1, wb_busy_clear  output  1  ARF commit write.
REQ-014 SHALL have ports free_tag  output  5, free_valid  output  1  RRF tag release.
REQ-015 SHALL have port flush  input  1  discard all entries.

Function
REQ-016 Each entry SHALL hold valid, done, wr, dest[2:0], tag[4:0], data[15:0]; circular buffer with head, tail, count.
REQ-017 Dispatch SHALL be accepted only when rob_full=0; when rob_full=1 both requests are dropped and no state changes.
REQ-018 instr_1 SHALL be written at tail and instr_2 at tail+1; tail advances by number accepted (0,1,2), wrapping mod 16.
REQ-019 disp_valid_2 without disp_valid_1 SHALL be ignored.
REQ-020 Entries with dest=0 SHALL store wr=0 (R0 never written, no tag freed).
REQ-021 rob_full SHALL be (count >= 15), from registered count; no same-cycle credit for commit.
REQ-022 Completion SHALL write data and set done at cmp_idx only if that entry is valid; otherwise ignored.
REQ-023 Commit SHALL occur when head entry is valid and done (registered state): at most one per cycle, head advances at that edge.
REQ-024 Commit outputs SHALL be combinational from head entry: wb_valid=commit&wr, wb_arf_addr=dest, wb_data=data, free_valid=commit&wr, free_tag=tag; all 0 when no commit.
REQ-025 wb_busy_clear SHALL be wb_valid & (commit_arf_tag==head tag) & no accepted dispatch this cycle with wr=1 to the same dest.
REQ-026 Completion to head index in cycle N SHALL commit in cycle N+1 (one-cycle latency minimum).
REQ-027 rob_count SHALL update as count + accepted - committed; simultaneous dispatch and commit allowed.
REQ-028 flush SHALL have priority: clear all valid/done, head=tail=count=0; dispatch, completion and commit ignored and commit outputs forced 0 that cycle.

Reset
REQ-029 On rst SHALL clear all valid/done, head=tail=0, count=0.
REQ-030 During and after reset SHALL drive rob_count=0, rob_full=0, disp_idx_1=0, disp_idx_2=1, wb_valid=0, wb_busy_clear=0, free_valid=0, wb_arf_addr=0, wb_data=0, free_tag=0.
REQ-031 rst asserted mid-operation SHALL discard all entries immediately, no commit issued.

Structure
REQ-032 Package rob_pkg SHALL hold ROB_DEPTH, ROB_IDX_W=4, TAG_W=5, DATA_W=16, ARF_ADDR_W=3 and struct rob_entry_t.
REQ-033 Block SHALL be a single module, no sub-module; entry array as flat registers.

Verification
REQ-034 Reset, dispatch (dest=3,tag=5,wr=1) idx0; complete idx0 data=0x1234 -> next cycle wb_valid=1, wb_arf_addr=3, wb_data=0x1234, free_tag=5, count 1->0.
REQ-035 Dispatch two, complete idx1 before idx0 -> no commit until idx0 done; then idx0, idx1 commit on consecutive cycles.
REQ-036 Fill 15 entries -> rob_full=1; dual dispatch dropped; commit one -> rob_full=0 next cycle; tail wrap 15->0 verified.
REQ-037 Commit dest=2 tag=7 with commit_arf_tag=9 -> wb_busy_clear=0; with commit_arf_tag=7 and same-cycle dispatch wr dest=2 -> wb_busy_clear=0; no dispatch -> 1.
REQ-038 Flush with 4 entries and cmp_valid on head -> no commit, count=0, disp_idx_1=0 next cycle; dest=0 entry commits with wb_valid=0, free_valid=0.

Source files
------------

// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rob_pkg
// Description : Shared sizes and the entry record for the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = 4;
  localparam int TAG_W      = 5;
  localparam int DATA_W     = 16;
  localparam int ARF_ADDR_W = 3;

  // One in-flight instruction. wr is stored already qualified by dest != 0,
  // so commit logic never has to special-case R0.
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  wr;
    logic [ARF_ADDR_W-1:0] dest;
    logic [TAG_W-1:0]      tag;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Dual-dispatch, single-commit circular reorder buffer. Tracks
//               in-order retirement of instructions, writes results back to
//               the ARF and releases their rename (RRF) tags.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   disp_valid/dest/wr/tag_1,_2  dispatch of two instructions (_1 is older)
//   disp_idx_1/_2                ROB slots assigned (tail, tail+1)
//   rob_full, rob_count          occupancy status (registered)
//   cmp_valid/idx/data           execution completion
//   commit_arf_tag               current ARF tag of wb_arf_addr
//   wb_valid/arf_addr/data       ARF commit write
//   wb_busy_clear                clear the ARF busy bit of wb_arf_addr
//   free_valid/free_tag          RRF tag release
//   flush                        discard every entry
// ============================================================================
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_valid_1,
  input  logic                  disp_valid_2,
  input  logic [ARF_ADDR_W-1:0] disp_dest_1,
  input  logic [ARF_ADDR_W-1:0] disp_dest_2,
  input  logic                  disp_wr_1,
  input  logic                  disp_wr_2,
  input  logic [TAG_W-1:0]      disp_tag_1,
  input  logic [TAG_W-1:0]      disp_tag_2,
  output logic [ROB_IDX_W-1:0]  disp_idx_1,
  output logic [ROB_IDX_W-1:0]  disp_idx_2,
  output logic                  rob_full,
  output logic [ROB_IDX_W:0]    rob_count,
  input  logic                  cmp_valid,
  input  logic [ROB_IDX_W-1:0]  cmp_idx,
  input  logic [DATA_W-1:0]     cmp_data,
  input  logic [TAG_W-1:0]      commit_arf_tag,
  output logic [ARF_ADDR_W-1:0] wb_arf_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_valid,
  output logic                  wb_busy_clear,
  output logic [TAG_W-1:0]      free_tag,
  output logic                  free_valid,
  input  logic                  flush
);

  // Two slots must be free so a dual dispatch can always be taken whole.
  localparam logic [ROB_IDX_W:0] c_full_level = (ROB_IDX_W + 1)'(ROB_DEPTH - 1);

  rob_entry_t               r_rob [ROB_DEPTH];
  logic [ROB_IDX_W-1:0]     r_head;
  logic [ROB_IDX_W-1:0]     r_tail;
  logic [ROB_IDX_W:0]       r_count;

  logic                     w_full;
  logic                     w_acc1;
  logic                     w_acc2;
  logic                     w_wr1;
  logic                     w_wr2;
  logic [1:0]               w_n_acc;
  logic [ROB_IDX_W-1:0]     w_tail_p1;
  rob_entry_t               w_head;
  logic                     w_commit;
  logic                     w_disp_hit;
  rob_entry_t               w_ent1;
  rob_entry_t               w_ent2;

  // --------------------------------------------------------------------------
  // Dispatch acceptance
  // --------------------------------------------------------------------------
  assign w_full    = (r_count >= c_full_level);
  assign w_acc1    = disp_valid_1 & ~w_full & ~flush;
  assign w_acc2    = w_acc1 & disp_valid_2;       // _2 alone is never taken
  assign w_wr1     = disp_wr_1 & (disp_dest_1 != '0);
  assign w_wr2     = disp_wr_2 & (disp_dest_2 != '0);
  assign w_n_acc   = {1'b0, w_acc1} + {1'b0, w_acc2};
  assign w_tail_p1 = r_tail + {{(ROB_IDX_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_ent1       = '0;
    w_ent1.valid = 1'b1;
    w_ent1.wr    = w_wr1;
    w_ent1.dest  = disp_dest_1;
    w_ent1.tag   = disp_tag_1;
    w_ent2       = '0;
    w_ent2.valid = 1'b1;
    w_ent2.wr    = w_wr2;
    w_ent2.dest  = disp_dest_2;
    w_ent2.tag   = disp_tag_2;
  end

  assign disp_idx_1 = r_tail;
  assign disp_idx_2 = w_tail_p1;
  assign rob_full   = w_full;
  assign rob_count  = r_count;

  // --------------------------------------------------------------------------
  // Commit (combinational from the registered head entry)
  // --------------------------------------------------------------------------
  assign w_head   = r_rob[r_head];
  assign w_commit = w_head.valid & w_head.done & ~flush;

  // A younger instruction renaming the same register this cycle takes over
  // the busy bit, so the retiring one must not clear it.
  assign w_disp_hit = (w_acc1 & w_wr1 & (disp_dest_1 == w_head.dest)) |
                      (w_acc2 & w_wr2 & (disp_dest_2 == w_head.dest));

  assign wb_valid      = w_commit & w_head.wr;
  assign wb_arf_addr   = w_commit ? w_head.dest : '0;
  assign wb_data       = w_commit ? w_head.data : '0;
  assign free_valid    = w_commit & w_head.wr;
  assign free_tag      = w_commit ? w_head.tag : '0;
  assign wb_busy_clear = wb_valid & (commit_arf_tag == w_head.tag) & ~w_disp_hit;

  // --------------------------------------------------------------------------
  // State update. Only free slots receive dispatches (count <= 14 when
  // accepting), so dispatch never collides with completion or commit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i].valid <= 1'b0;
        r_rob[i].done  <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (cmp_valid && r_rob[cmp_idx].valid) begin
        r_rob[cmp_idx].data <= cmp_data;
        r_rob[cmp_idx].done <= 1'b1;
      end
      if (w_commit) begin
        r_rob[r_head].valid <= 1'b0;
        r_rob[r_head].done  <= 1'b0;
        r_head              <= r_head + {{(ROB_IDX_W-1){1'b0}}, 1'b1};
      end
      if (w_acc1) begin
        r_rob[r_tail] <= w_ent1;
      end
      if (w_acc2) begin
        r_rob[w_tail_p1] <= w_ent2;
      end
      r_tail  <= r_tail + {{(ROB_IDX_W-2){1'b0}}, w_n_acc};
      r_count <= r_count + {{(ROB_IDX_W-1){1'b0}}, w_n_acc}
                         - {{ROB_IDX_W{1'b0}}, w_commit};
    end
  end

endmodule : reorder_buffer
`default_nettype wire
